// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
// Holds the FSM state enum, owner encoding and default bus widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 8;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for CPU vs debug, zero latency, no backpressure.
// ARB_ROUND_ROBIN_EN: on contention grant the non-owner; otherwise CPU has fixed priority.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic cpu_req,
   input  logic dbg_req,
   input  logic owner,
   output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      winner = OWN_CPU;
      if (cpu_req && dbg_req) begin
         winner = ~owner;
      end else if (dbg_req) begin
         winner = OWN_DBG;
      end
   end
`else
   logic unused_owner;
   assign unused_owner = owner;

   always_comb begin
      winner = OWN_CPU;
      if (dbg_req && !cpu_req) begin
         winner = OWN_DBG;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between a CPU and a read-only debug port; ack 2 cycles after grant.
// Requesters hold req until ack, one grant per 3 cycles; policy set by ARB_ROUND_ROBIN_EN in arb_pick.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              winner;

   arb_pick u_pick (
      .cpu_req (cpu_req),
      .dbg_req (dbg_req),
      .owner   (owner_q),
      .winner  (winner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      cpu_ack     = 1'b0;
      dbg_ack     = 1'b0;
      cpu_rdata   = cpu_rdata_q;
      dbg_rdata   = dbg_rdata_q;

      case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               state_d = ACCESS;
               owner_d = winner;
               if (winner == OWN_DBG) begin
                  addr_d  = dbg_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end else begin
                  addr_d  = cpu_addr;
                  we_d    = cpu_we;
                  wdata_d = cpu_wdata;
               end
            end
         end
         ACCESS: begin
            ram_en  = 1'b1;
            ram_we  = we_q;
            state_d = RESP;
         end
         RESP: begin
            // RAM data arrives this cycle, so it is forwarded while ack is high and held afterwards.
            if (owner_q == OWN_DBG) begin
               dbg_ack     = 1'b1;
               dbg_rdata   = ram_rdata;
               dbg_rdata_d = ram_rdata;
            end else begin
               cpu_ack     = 1'b1;
               cpu_rdata   = ram_rdata;
               cpu_rdata_d = ram_rdata;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and random
// transactions against a transaction-level model with its own RAM contents.
module tb_mem_port_arbiter;

   localparam int AW = 11;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dbg_req;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack, dbg_ack, ram_en, ram_we, busy, owner;
   logic [DW-1:0] cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .dbg_req   (dbg_req),
      .dbg_addr  (dbg_addr),
      .dbg_ack   (dbg_ack),
      .dbg_rdata (dbg_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   function automatic logic [7:0] init_val(int a);
      return (a == 5) ? 8'hA7 : 8'((a * 7 + 3) ^ (a >> 3));
   endfunction

   // Read-first synchronous RAM, loaded on its first clock edge (under reset).
   logic [DW-1:0] ram_mem [0:2**AW-1];
   bit            ram_loaded;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 2**AW; i++) ram_mem[i] <= init_val(i);
         ram_loaded <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Transaction-level model state.
   logic [DW-1:0] ref_mem [0:2**AW-1];
   logic          last_owner;
   logic [DW-1:0] exp_cpu_rd, exp_dbg_rd;
   bit            cpu_rd_known, dbg_rd_known;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Returns 1 when debug wins the next grant.
   function automatic bit first_winner(bit c, bit d);
      if (c && d) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !last_owner;
`else
         return 1'b0;
`endif
      end
      return d;
   endfunction

   // Called at posedge+1 with the arbiter idle; raises the selected requests and
   // checks every cycle until both are served and the bus is idle again.
   task automatic pair_txn(input bit c_on, input bit c_we, input logic [AW-1:0] c_addr,
                           input logic [DW-1:0] c_wd, input bit d_on,
                           input logic [AW-1:0] d_addr, input string nm);
      int t_c, t_d, t_end;
      bit dbg_first;
      logic [DW-1:0] exp_c, exp_d;
      t_c = 0; t_d = 0; exp_c = '0; exp_d = '0;
      if (!c_on && !d_on) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk({nm, " idle busy"}, busy, 0);
            chk({nm, " idle acks"}, {cpu_ack, dbg_ack}, 0);
         end
         @(posedge clk); #1;
         return;
      end
      dbg_first = first_winner(c_on, d_on);
      if (c_on) t_c = (d_on && dbg_first) ? 6 : 3;
      if (d_on) t_d = (c_on && !dbg_first) ? 6 : 3;
      if (d_on && t_d == 3) exp_d = ref_mem[d_addr];
      if (c_on) begin
         exp_c = ref_mem[c_addr];
         if (c_we) ref_mem[c_addr] = c_wd;
      end
      if (d_on && t_d == 6) exp_d = ref_mem[d_addr];
      t_end = ((t_c > t_d) ? t_c : t_d) + 1;

      cpu_req = c_on; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      dbg_req = d_on; dbg_addr = d_addr;
      for (int c = 1; c <= t_end; c++) begin
         @(negedge clk);
         chk($sformatf("%s cpu_ack c%0d", nm, c), cpu_ack, c == t_c);
         chk($sformatf("%s dbg_ack c%0d", nm, c), dbg_ack, c == t_d);
         chk($sformatf("%s ram_en c%0d", nm, c), ram_en, (c == t_c - 1) || (c == t_d - 1));
         if (c == t_c - 1) begin
            chk({nm, " cpu ram_addr"}, ram_addr, c_addr);
            chk({nm, " cpu ram_we"}, ram_we, c_we);
            if (c_we) chk({nm, " cpu ram_wdata"}, ram_wdata, c_wd);
         end
         if (c == t_d - 1) begin
            chk({nm, " dbg ram_addr"}, ram_addr, d_addr);
            chk({nm, " dbg ram_we"}, ram_we, 0);
         end
         if (c == t_c) begin
            chk({nm, " cpu owner"}, owner, 0);
            if (!c_we) begin
               chk({nm, " cpu_rdata"}, cpu_rdata, exp_c);
               exp_cpu_rd = exp_c;
               cpu_rd_known = 1'b1;
            end else begin
               cpu_rd_known = 1'b0;
            end
            last_owner = 1'b0;
            @(posedge clk); #1;
            cpu_req = 1'b0;
         end
         if (c == t_d) begin
            chk({nm, " dbg owner"}, owner, 1);
            chk({nm, " dbg_rdata"}, dbg_rdata, exp_d);
            exp_dbg_rd = exp_d;
            dbg_rd_known = 1'b1;
            last_owner = 1'b1;
            @(posedge clk); #1;
            dbg_req = 1'b0;
         end
         if (c == t_end) chk({nm, " busy after"}, busy, 0);
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit            dbg;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] exp_rd;
      bit            chk_rd;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 11'h005, 8'h00, 8'hA7, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 11'h7FF, 8'h3C, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 11'h7FF, 8'h00, 8'h3C, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 11'h7FF, 8'h00, 8'h3C, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 11'h000, 8'h5E, 8'h00, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 11'h000, 8'h00, 8'h5E, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 11'h005, 8'h00, 8'hA7, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 11'h400, 8'hC3, 8'h00, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 11'h400, 8'h00, 8'hC3, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 11'h400, 8'h00, 8'hC3, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 11'h005, 8'h00, 8'hA7, 1'b1};

      for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);
      last_owner = 1'b0;
      exp_cpu_rd = '0; exp_dbg_rd = '0;
      cpu_rd_known = 1'b1; dbg_rd_known = 1'b1;

      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_addr = '0;
      #2;
      chk("reset busy", busy, 0);
      chk("reset ram_en/we", {ram_en, ram_we}, 0);
      chk("reset acks", {cpu_ack, dbg_ack}, 0);
      chk("reset owner", owner, 0);
      chk("reset rdata", {cpu_rdata, dbg_rdata}, 0);
      chk("reset ram_addr", ram_addr, 0);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         pair_txn(!tbl[i].dbg, tbl[i].we, tbl[i].addr, tbl[i].wd,
                  tbl[i].dbg, tbl[i].addr, $sformatf("vec%0d", i));
         if (tbl[i].chk_rd)
            chk($sformatf("vec%0d table rdata", i),
                tbl[i].dbg ? dbg_rdata : cpu_rdata, tbl[i].exp_rd);
      end

      // Contention: both requesters held for four grants.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
      dbg_req = 1'b1; dbg_addr = 11'h005;
      for (int c = 1; c <= 13; c++) begin
         bit is_ack, w;
         @(negedge clk);
         is_ack = (c % 3 == 0) && (c <= 12);
         w = first_winner(1'b1, 1'b1);
         chk($sformatf("contend cpu_ack c%0d", c), cpu_ack, is_ack && !w);
         chk($sformatf("contend dbg_ack c%0d", c), dbg_ack, is_ack && w);
         if (is_ack) begin
            chk($sformatf("contend owner c%0d", c), owner, w);
            if (w) begin
               chk("contend dbg_rdata", dbg_rdata, ref_mem[11'h005]);
               exp_dbg_rd = ref_mem[11'h005];
               dbg_rd_known = 1'b1;
            end else begin
               chk("contend cpu_rdata", cpu_rdata, ref_mem[11'h7FF]);
               exp_cpu_rd = ref_mem[11'h7FF];
               cpu_rd_known = 1'b1;
            end
            last_owner = w;
         end
         if (c == 12) begin
            @(posedge clk); #1;
            cpu_req = 1'b0; dbg_req = 1'b0;
         end
         if (c == 13) chk("contend busy end", busy, 0);
      end
      @(posedge clk); #1;

      // Debug request pulsed for one cycle still completes.
      dbg_req = 1'b1; dbg_addr = 11'h010;
      @(posedge clk); #1;
      dbg_req = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("drop dbg_ack c%0d", c), dbg_ack, c == 3);
         chk($sformatf("drop ram_en c%0d", c), ram_en, c == 2);
         if (c == 3) chk("drop dbg_rdata", dbg_rdata, ref_mem[11'h010]);
         if (c == 4) chk("drop busy", busy, 0);
      end
      exp_dbg_rd = ref_mem[11'h010];
      last_owner = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a CPU write.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'h99;
      @(negedge clk);
      @(negedge clk);
      chk("rst-mid ram_en before", ram_en, 1);
      #1 reset = 1'b1;
      #1;
      chk("rst-mid busy", busy, 0);
      chk("rst-mid ram_en/we", {ram_en, ram_we}, 0);
      chk("rst-mid ram_addr/wdata", {ram_addr, ram_wdata}, 0);
      chk("rst-mid acks", {cpu_ack, dbg_ack}, 0);
      chk("rst-mid owner", owner, 0);
      chk("rst-mid rdata", {cpu_rdata, dbg_rdata}, 0);
      @(negedge clk);
      chk("rst-mid held acks", {cpu_ack, dbg_ack}, 0);
      reset = 1'b0;
      last_owner = 1'b0;
      exp_cpu_rd = '0; exp_dbg_rd = '0;
      cpu_rd_known = 1'b1; dbg_rd_known = 1'b1;
      @(negedge clk);
      chk("rst-mid regrant ram_en", ram_en, 1);
      chk("rst-mid regrant early ack", cpu_ack, 0);
      @(negedge clk);
      chk("rst-mid regrant ack", cpu_ack, 1);
      chk("rst-mid dbg_rdata kept 0", dbg_rdata, 0);
      ref_mem[11'h123] = 8'h99;
      cpu_rd_known = 1'b0;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      pair_txn(1'b0, 1'b0, '0, '0, 1'b1, 11'h123, "rst-mid readback");

      // Random transactions.
      for (int i = 0; i < 40; i++) begin
         bit c_on, d_on, c_we;
         logic [AW-1:0] ca, da;
         c_on = 1'($urandom_range(0, 1));
         d_on = 1'($urandom_range(0, 1));
         c_we = 1'($urandom_range(0, 1));
         ca = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 2**AW - 1));
         da = ($urandom_range(0, 3) == 0) ? ca : 11'($urandom_range(0, 2**AW - 1));
         pair_txn(c_on, c_we, ca, 8'($urandom_range(0, 255)), d_on, da,
                  $sformatf("rnd%0d", i));
      end

      // Long idle: nothing moves, rdata registers hold.
      pair_txn(1'b1, 1'b0, 11'h0AA, '0, 1'b1, 11'h055, "pre-idle");
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         chk($sformatf("idle busy/en c%0d", c), {busy, ram_en}, 0);
         chk($sformatf("idle acks c%0d", c), {cpu_ack, dbg_ack}, 0);
      end
      if (cpu_rd_known) chk("idle cpu_rdata hold", cpu_rdata, exp_cpu_rd);
      if (dbg_rd_known) chk("idle dbg_rdata hold", dbg_rdata, exp_dbg_rd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
